multi_channel_checker: RTL

- Synthesizable, parametrised successor to the single-stream mismatch checker and error counter used in file-driven test environments.
- Compares CHANNELS actual sample streams against expected streams, one compare per valid sample.
- Supports tolerance, a settle window, per-channel saturating error counters, end-of-vector detection and a sticky pass/fail verdict.
- Sits between the stimulus reader and the DUT outputs, in a bench or in on-chip self-test.

---
 rtl/checker_pkg.sv | 18 +
 rtl/abs_diff_cmp.sv | 21 ++
 rtl/multi_channel_checker.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared state type and saturating increment for multi_channel_checker
package checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } checker_state_t;

    // Counters are at most 32 bits wide; callers truncate the result to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_value;
        max_value = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/abs_diff_cmp.sv
// rtl/abs_diff_cmp.sv - signed absolute difference of two samples against a tolerance
module abs_diff_cmp #(
    parameter int DATA_WIDTH = 16,
    parameter int TOLERANCE  = 0
) (
    input  logic [DATA_WIDTH-1:0] actual,
    input  logic [DATA_WIDTH-1:0] expected,
    output logic                  mismatch
);

    localparam logic [DATA_WIDTH:0] TOL = (DATA_WIDTH + 1)'(TOLERANCE);

    logic signed [DATA_WIDTH:0] delta;
    logic        [DATA_WIDTH:0] magnitude;

    // One extra bit keeps the full-scale difference (e.g. min minus max) representable.
    assign delta     = $signed({actual[DATA_WIDTH-1], actual}) - $signed({expected[DATA_WIDTH-1], expected});
    assign magnitude = delta[DATA_WIDTH] ? $unsigned(-delta) : $unsigned(delta);
    assign mismatch  = magnitude > TOL;

endmodule

// File: rtl/multi_channel_checker.sv
// rtl/multi_channel_checker.sv - multi-channel stream compare with error counters and sticky verdict
// Defining FIRST_ERR_CAPTURE_EN adds first-mismatch index/channel capture outputs.
module multi_channel_checker
    import checker_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int CHANNELS       = 4,
    parameter int TOLERANCE      = 0,
    parameter int ERR_CNT_WIDTH  = 16,
    parameter int VECTOR_LEN     = 1024,
    parameter int SETTLE_SAMPLES = 2,
    localparam int SC_WIDTH      = $clog2(VECTOR_LEN + 1),
    localparam int CH_WIDTH      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              sample_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]    actual,
    input  logic [CHANNELS*DATA_WIDTH-1:0]    expected,
    output logic                              busy,
    output logic                              done,
    output logic                              test_passed,
    output logic [CHANNELS-1:0]               mismatch,
    output logic [CHANNELS*ERR_CNT_WIDTH-1:0] err_count,
    output logic [ERR_CNT_WIDTH-1:0]          total_errors,
    output logic [SC_WIDTH-1:0]               samples_checked
`ifdef FIRST_ERR_CAPTURE_EN
    ,
    output logic [SC_WIDTH-1:0]               first_err_index,
    output logic [CH_WIDTH-1:0]               first_err_channel,
    output logic                              first_err_valid
`endif
);

    localparam int ST_WIDTH = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

    checker_state_t            state;
    logic [ST_WIDTH-1:0]       settle_count;
    logic [CHANNELS-1:0]       cmp_mismatch;
    logic [ERR_CNT_WIDTH-1:0]  err_cnt_q [CHANNELS];

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_cmp
        abs_diff_cmp #(
            .DATA_WIDTH (DATA_WIDTH),
            .TOLERANCE  (TOLERANCE)
        ) u_cmp (
            .actual   (actual[ch*DATA_WIDTH +: DATA_WIDTH]),
            .expected (expected[ch*DATA_WIDTH +: DATA_WIDTH]),
            .mismatch (cmp_mismatch[ch])
        );
        assign err_count[ch*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = err_cnt_q[ch];
    end

`ifdef FIRST_ERR_CAPTURE_EN
    logic [CH_WIDTH-1:0] lowest_ch;
    always_comb begin
        lowest_ch = '0;
        for (int ch = CHANNELS - 1; ch >= 0; ch--) begin
            if (cmp_mismatch[ch]) lowest_ch = CH_WIDTH'(ch);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            test_passed     <= 1'b1;
            mismatch        <= '0;
            total_errors    <= '0;
            samples_checked <= '0;
            settle_count    <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) err_cnt_q[ch] <= '0;
`ifdef FIRST_ERR_CAPTURE_EN
            first_err_index   <= '0;
            first_err_channel <= '0;
            first_err_valid   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        test_passed     <= 1'b1;
                        mismatch        <= '0;
                        total_errors    <= '0;
                        samples_checked <= '0;
                        settle_count    <= '0;
                        for (int ch = 0; ch < CHANNELS; ch++) err_cnt_q[ch] <= '0;
`ifdef FIRST_ERR_CAPTURE_EN
                        first_err_index   <= '0;
                        first_err_channel <= '0;
                        first_err_valid   <= 1'b0;
`endif
                        state <= (SETTLE_SAMPLES > 0) ? SETTLE : CHECK;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (sample_valid) begin
                        settle_count <= settle_count + 1'b1;
                        if (settle_count == ST_WIDTH'(SETTLE_SAMPLES - 1)) state <= CHECK;
                    end
                end
                CHECK: begin
                    if (sample_valid) begin
                        mismatch <= cmp_mismatch;
                        for (int ch = 0; ch < CHANNELS; ch++) begin
                            if (cmp_mismatch[ch])
                                err_cnt_q[ch] <= ERR_CNT_WIDTH'(sat_inc(32'(err_cnt_q[ch]), ERR_CNT_WIDTH));
                        end
                        if (|cmp_mismatch) begin
                            total_errors <= ERR_CNT_WIDTH'(sat_inc(32'(total_errors), ERR_CNT_WIDTH));
                            test_passed  <= 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
                            if (!first_err_valid) begin
                                first_err_index   <= samples_checked;
                                first_err_channel <= lowest_ch;
                                first_err_valid   <= 1'b1;
                            end
`endif
                        end
                        samples_checked <= samples_checked + 1'b1;
                        if (samples_checked == SC_WIDTH'(VECTOR_LEN - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
